// File: rtl/tipos_pacotes.sv
// Shared types and constants for the seven-segment display path.
package tipos_pacotes;

    typedef logic [3:0] bcdPac_t;

    localparam logic [6:0] SEG_APAGADO = 7'b1111111;
    localparam logic [6:0] SEG_TRACO   = 7'b0111111;
    localparam bcdPac_t    BCD_TRACO   = 4'hA;
    localparam bcdPac_t    BCD_APAGADO = 4'hB;

    typedef enum logic [0:0] {
        LIVRE = 1'b0,
        ATIVO = 1'b1
    } estado_disp_t;

endpackage

// File: rtl/decodificador_7seg.sv
// Combinational BCD-to-seven-segment decoder, active-low; codes above 4'hA blank.
module decodificador_7seg
    import tipos_pacotes::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Code-to-segment lookup; every code maps to a defined pattern
    always_comb begin
        seg = SEG_APAGADO;
        case (bcd)
            4'd0:        seg = 7'b1000000;
            4'd1:        seg = 7'b1111001;
            4'd2:        seg = 7'b0100100;
            4'd3:        seg = 7'b0110000;
            4'd4:        seg = 7'b0011001;
            4'd5:        seg = 7'b0010010;
            4'd6:        seg = 7'b0000010;
            4'd7:        seg = 7'b1111000;
            4'd8:        seg = 7'b0000000;
            4'd9:        seg = 7'b0011000;
            BCD_TRACO:   seg = SEG_TRACO;
            BCD_APAGADO: seg = SEG_APAGADO;
            default:     seg = SEG_APAGADO;
        endcase
    end

endmodule

// File: rtl/display_multifonte.sv
// Multi-source seven-segment controller: fixed-priority ownership, per-digit blink,
// registered active-low segment outputs.
module display_multifonte
    import tipos_pacotes::*;
#(
    parameter int NUM_DIG    = 6,
    parameter int NUM_FONTES = 2,
    parameter int BLINK_DIV  = 25_000_000
)
(
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic [NUM_FONTES-1:0]                                 enable,
    input  logic [NUM_FONTES*NUM_DIG*4-1:0]                       bcd_in,
    input  logic [NUM_FONTES*NUM_DIG-1:0]                         blink_mask,
    output logic [NUM_DIG*7-1:0]                                  hex,
    output logic [((NUM_FONTES > 1) ? $clog2(NUM_FONTES) : 1)-1:0] dono,
    output logic                                                  ocupado
);

    localparam int DONO_W = (NUM_FONTES > 1) ? $clog2(NUM_FONTES) : 1;
    localparam int CNT_W  = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

    estado_disp_t          state_r;
    logic [DONO_W-1:0]     dono_r;
    logic                  ocupado_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  phase_r;
    logic [NUM_DIG*7-1:0]  hex_r;

    logic                  any_en_s;
    logic [DONO_W-1:0]     prio_s;
    logic                  own_en_s;
    logic [NUM_DIG*4-1:0]  bcd_sel_s;
    logic [NUM_DIG-1:0]    mask_sel_s;
    logic [NUM_DIG*7-1:0]  seg_s;
    logic [NUM_DIG*7-1:0]  hex_next_s;

    assign any_en_s = |enable;

    // Lowest requesting index wins; owner's enable, digits and mask are muxed out
    always_comb begin
        prio_s     = '0;
        own_en_s   = 1'b0;
        bcd_sel_s  = '0;
        mask_sel_s = '0;
        for (int f = NUM_FONTES - 1; f >= 0; f--) begin
            prio_s = enable[f] ? DONO_W'(f) : prio_s;
        end
        for (int f = 0; f < NUM_FONTES; f++) begin
            own_en_s   = (dono_r == DONO_W'(f)) ? enable[f] : own_en_s;
            bcd_sel_s  = (dono_r == DONO_W'(f)) ? bcd_in[f*NUM_DIG*4 +: NUM_DIG*4] : bcd_sel_s;
            mask_sel_s = (dono_r == DONO_W'(f)) ? blink_mask[f*NUM_DIG +: NUM_DIG] : mask_sel_s;
        end
    end

    for (genvar i = 0; i < NUM_DIG; i++) begin : g_dec
        decodificador_7seg u_dec (
            .bcd (bcd_sel_s[i*4 +: 4]),
            .seg (seg_s[i*7 +: 7])
        );
    end

    // Ownership FSM: no preemption, every handoff passes through LIVRE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= LIVRE;
            dono_r    <= '0;
            ocupado_r <= 1'b0;
        end else begin
            case (state_r)
                LIVRE: begin
                    if (any_en_s) begin
                        state_r   <= ATIVO;
                        dono_r    <= prio_s;
                        ocupado_r <= 1'b1;
                    end
                end
                ATIVO: begin
                    if (!own_en_s) begin
                        state_r   <= LIVRE;
                        ocupado_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= LIVRE;
                    ocupado_r <= 1'b0;
                end
            endcase
        end
    end

    // Blink divider; held at zero in LIVRE so a new owner starts visible
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= '0;
            phase_r <= 1'b0;
        end else if (state_r == LIVRE) begin
            cnt_r   <= '0;
            phase_r <= 1'b0;
        end else if (cnt_r == CNT_MAX) begin
            cnt_r   <= '0;
            phase_r <= ~phase_r;
        end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
        end
    end

    // Next segment image: blank outside ATIVO, masked digits blank in phase 1
    always_comb begin
        hex_next_s = {NUM_DIG{SEG_APAGADO}};
        for (int i = 0; i < NUM_DIG; i++) begin
            hex_next_s[i*7 +: 7] = ((state_r == ATIVO) && !(phase_r && mask_sel_s[i]))
                                   ? seg_s[i*7 +: 7] : SEG_APAGADO;
        end
    end

    // Output register
    always_ff @(posedge clk) begin
        if (rst) begin
            hex_r <= {NUM_DIG{SEG_APAGADO}};
        end else begin
            hex_r <= hex_next_s;
        end
    end

    assign hex     = hex_r;
    assign dono    = dono_r;
    assign ocupado = ocupado_r;

endmodule

// File: tb/tb_display_multifonte.sv
// Scoreboard bench for display_multifonte: stimulus queues per-edge expectations,
// a negedge monitor pops and compares them.
module tb_display_multifonte;

    localparam int ND = 6;
    localparam int NF = 3;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0011000;
    localparam logic [6:0] SD = 7'b0111111;
    localparam logic [6:0] SB = 7'b1111111;

    localparam logic [41:0] BLANK6     = {SB, SB, SB, SB, SB, SB};
    localparam logic [41:0] SRC0       = {S9, S8, S7, S6, S5, S4};
    localparam logic [41:0] SRC0_BLINK = {S9, S8, S7, S6, SB, SB};
    localparam logic [41:0] SRC1       = {S5, S4, S3, S2, S1, S0};
    localparam logic [41:0] CODES      = {S7, S6, SD, SB, SB, S9};
    localparam logic [41:0] SRC2       = {S1, S2, S3, S4, S5, S6};

    typedef struct {
        int          cyc;
        logic [41:0] hex;
        logic [1:0]  dono;
        logic        ocup;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [NF-1:0] enable;
    logic [NF*ND*4-1:0] bcd_in;
    logic [NF*ND-1:0]   blink_mask;
    logic [ND*7-1:0]    hex;
    logic [1:0]         dono;
    logic               ocupado;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc;
    int   n_cmp;
    int   n_bad;

    display_multifonte #(
        .NUM_DIG    (ND),
        .NUM_FONTES (NF),
        .BLINK_DIV  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .bcd_in     (bcd_in),
        .blink_mask (blink_mask),
        .hex        (hex),
        .dono       (dono),
        .ocupado    (ocupado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int d, input logic [41:0] h, input logic [1:0] dn, input logic oc);
        exp_t e;
        e.cyc  = cyc + d;
        e.hex  = h;
        e.dono = dn;
        e.ocup = oc;
        sb_q.push_back(e);
    endtask

    task automatic set_bcd(input int f, input logic [23:0] digits);
        bcd_in[f*24 +: 24] = digits;
    endtask

    // Monitor: after each edge, compare every expectation targeted at that edge
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            mon_e = sb_q.pop_front();
            if (mon_e.cyc != cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL stale: expectation for edge %0d seen at edge %0d", mon_e.cyc, cyc);
            end else begin
                n_cmp += 3;
                if (hex !== mon_e.hex) begin
                    n_bad++;
                    $display("FAIL hex @edge %0d: got %h, want %h", cyc, hex, mon_e.hex);
                end
                if (dono !== mon_e.dono) begin
                    n_bad++;
                    $display("FAIL dono @edge %0d: got %0d, want %0d", cyc, dono, mon_e.dono);
                end
                if (ocupado !== mon_e.ocup) begin
                    n_bad++;
                    $display("FAIL ocupado @edge %0d: got %b, want %b", cyc, ocupado, mon_e.ocup);
                end
            end
        end
    end

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b1;
        enable     = 3'b111;
        bcd_in     = '0;
        blink_mask = '0;
        set_bcd(0, 24'h987654);
        set_bcd(1, 24'h543210);
        set_bcd(2, 24'h123456);

        // Reset held with all enables high
        push(1, BLANK6, 2'd0, 1'b0);
        push(2, BLANK6, 2'd0, 1'b0);
        step(2);
        rst = 1'b0;
        push(1, BLANK6, 2'd0, 1'b1);
        push(2, SRC0,   2'd0, 1'b1);
        step(2);
        enable = 3'b000;
        push(1, SRC0,   2'd0, 1'b0);
        push(2, BLANK6, 2'd0, 1'b0);
        step(2);

        // Priority among 1 and 2, then live data change with A/B/F/9 codes
        enable = 3'b110;
        push(1, BLANK6, 2'd1, 1'b1);
        push(2, SRC1,   2'd1, 1'b1);
        step(2);
        set_bcd(1, 24'h76ABF9);
        push(1, CODES, 2'd1, 1'b1);
        step(1);

        // Owner 1 drops while 2 requests: one LIVRE cycle then grant
        enable = 3'b100;
        push(1, CODES,  2'd1, 1'b0);
        push(2, BLANK6, 2'd2, 1'b1);
        push(3, SRC2,   2'd2, 1'b1);
        step(3);

        // Source 0 requests while 2 owns: no preemption
        enable = 3'b101;
        push(1, SRC2, 2'd2, 1'b1);
        push(2, SRC2, 2'd2, 1'b1);
        step(2);
        enable = 3'b001;
        blink_mask[5:0] = 6'b000011;
        push(1, SRC2,   2'd2, 1'b0);
        push(2, BLANK6, 2'd0, 1'b1);
        step(2);

        // Blink: visible 4 edges, blanked 4 edges, visible 4 edges
        for (int k = 1; k <= 12; k++) begin
            push(k, (((k - 1) / 4) % 2 == 1) ? SRC0_BLINK : SRC0, 2'd0, 1'b1);
        end
        step(12);

        // Release during blank phase, re-acquire: must restart visible
        enable = 3'b000;
        push(1, SRC0_BLINK, 2'd0, 1'b0);
        step(1);
        enable = 3'b001;
        push(1, BLANK6, 2'd0, 1'b1);
        for (int k = 2; k <= 7; k++) begin
            push(k, (k >= 6) ? SRC0_BLINK : SRC0, 2'd0, 1'b1);
        end
        step(7);

        // Reset in the blank phase, then counter restarts from zero
        rst = 1'b1;
        push(1, BLANK6, 2'd0, 1'b0);
        step(1);
        rst = 1'b0;
        push(1, BLANK6, 2'd0, 1'b1);
        for (int k = 2; k <= 6; k++) begin
            push(k, (k == 6) ? SRC0_BLINK : SRC0, 2'd0, 1'b1);
        end
        step(6);

        for (int w = 0; w < 10 && sb_q.size() > 0; w++) begin
            step(1);
        end
        if (sb_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
